mac_r4_seq: RTL and testbench

Parametrised sequential multiply-accumulate unit. It computes one WIDTH×WIDTH product with an iterative radix-4 Booth multiplier, retiring one Booth digit per cycle, and adds the product into an ACC_WIDTH accumulator. Next generation of the fixed 256-bit MAC in the datapath, adding:

- a valid/ready input handshake
- per-operation signed/unsigned mode
- accumulator clear-on-issue
- a sticky overflow flag

---
 rtl/mac_r4_seq.sv | 114 +++++++++++
 tb/tb_mac_r4_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_r4_seq.sv
// Sequential multiply-accumulate: iterative radix-4 Booth multiplier (one digit per cycle)
// feeding a wrap-around accumulator with a valid/ready input handshake and sticky overflow.
module mac_r4_seq #(
  parameter int WIDTH     = 256,
  parameter int ACC_WIDTH = 520
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 op_signed,
  input  logic                 acc_clear,
  output logic                 out_valid,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 overflow
);

  localparam int N  = WIDTH/2 + 1;
  localparam int CW = $clog2(N);
  localparam int PW = 2*WIDTH + 2;

  typedef enum logic [1:0] {IDLE, MUL, ACC} state_t;

  state_t           state;
  logic [WIDTH+2:0] b_sh;   // {ext b, implicit 0}; shifted down 2 per iteration so digit is [2:0]
  logic [PW-1:0]    mcand;  // extended a; shifted up 2 per iteration to track the 2i weight
  logic [PW-1:0]    prod;
  logic [CW-1:0]    cnt;
  logic             sgn_q;
  logic             clr_q;

  logic [PW-1:0]        prod_nxt;
  logic [ACC_WIDTH-1:0] p_ext;
  logic [ACC_WIDTH-1:0] base;
  logic [ACC_WIDTH:0]   sum;
  logic                 ovf_evt;
  logic [1:0]           unused_prod_hi;

  assign unused_prod_hi = prod[PW-1:PW-2];

  always_comb begin
    prod_nxt = prod;
    case (b_sh[2:0])
      3'b001, 3'b010: prod_nxt = prod + mcand;
      3'b011:         prod_nxt = prod + (mcand << 1);
      3'b100:         prod_nxt = prod - (mcand << 1);
      3'b101, 3'b110: prod_nxt = prod - mcand;
      default:        prod_nxt = prod;
    endcase
  end

  always_comb begin
    p_ext                = {ACC_WIDTH{sgn_q & prod[2*WIDTH-1]}};
    p_ext[2*WIDTH-1:0]   = prod[2*WIDTH-1:0];
    base                 = clr_q ? '0 : acc_out;
    sum                  = {1'b0, base} + {1'b0, p_ext};
    if (sgn_q)
      ovf_evt = (base[ACC_WIDTH-1] == p_ext[ACC_WIDTH-1]) &&
                (sum[ACC_WIDTH-1] != base[ACC_WIDTH-1]);
    else
      ovf_evt = sum[ACC_WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      acc_out   <= '0;
      overflow  <= 1'b0;
      prod      <= '0;
      cnt       <= '0;
      mcand     <= '0;
      b_sh      <= '0;
      sgn_q     <= 1'b0;
      clr_q     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mcand    <= {{(PW-WIDTH){op_signed & a[WIDTH-1]}}, a};
            b_sh     <= {{2{op_signed & b[WIDTH-1]}}, b, 1'b0};
            sgn_q    <= op_signed;
            clr_q    <= acc_clear;
            prod     <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= MUL;
          end
        end
        MUL: begin
          prod  <= prod_nxt;
          mcand <= mcand << 2;
          b_sh  <= b_sh >> 2;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(N-1))
            state <= ACC;
        end
        ACC: begin
          acc_out   <= sum[ACC_WIDTH-1:0];
          overflow  <= (overflow & ~clr_q) | ovf_evt;
          out_valid <= 1'b1;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_r4_seq.sv
// Directed bench for mac_r4_seq at WIDTH=8/ACC_WIDTH=20, plus a WIDTH=16/ACC_WIDTH=40
// instance checked against a behavioural multiply/accumulate model.
module tb_mac_r4_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  logic        v8 = 1'b0, rdy8, vo8, of8, s8 = 1'b0, c8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [19:0] acc8;

  logic        v16 = 1'b0, rdy16, vo16, of16, s16 = 1'b0, c16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [39:0] acc16;

  mac_r4_seq #(.WIDTH(8), .ACC_WIDTH(20)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .a(a8), .b(b8),
    .op_signed(s8), .acc_clear(c8), .out_valid(vo8), .acc_out(acc8), .overflow(of8)
  );

  mac_r4_seq #(.WIDTH(16), .ACC_WIDTH(40)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16), .a(a16), .b(b16),
    .op_signed(s16), .acc_clear(c16), .out_valid(vo16), .acc_out(acc16), .overflow(of16)
  );

  // Issue one op on the 8-bit instance and wait for its result (latency bound doubles as timeout).
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic s, input logic c);
    int lat;
    a8 = ta; b8 = tb; s8 = s; c8 = c; v8 = 1'b1;
    lat = 0;
    while (!rdy8 && lat < 40) begin @(posedge clk); #1; lat++; end
    @(posedge clk); #1;
    v8 = 1'b0; a8 = ~ta; b8 = ~tb; s8 = ~s; c8 = ~c;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!vo8 && lat < 40);
    total++;
    if (lat != 6) begin bad++; $display("FAIL op8_latency got=%0d exp=6", lat); end
  endtask

  task automatic test_reset();
    total++; if (acc8 !== 20'd0) begin bad++; $display("FAIL rst_acc8 got=%0h exp=0", acc8); end
    total++; if (of8 !== 1'b0)   begin bad++; $display("FAIL rst_ovf8 got=%0b exp=0", of8); end
    total++; if (rdy8 !== 1'b1)  begin bad++; $display("FAIL rst_rdy8 got=%0b exp=1", rdy8); end
    total++; if (vo8 !== 1'b0)   begin bad++; $display("FAIL rst_vo8 got=%0b exp=0", vo8); end
    total++; if (acc16 !== 40'd0 || of16 !== 1'b0 || rdy16 !== 1'b1 || vo16 !== 1'b0) begin
      bad++; $display("FAIL rst_dut16 got=%0h/%0b/%0b/%0b exp=0/0/1/0", acc16, of16, rdy16, vo16);
    end
  endtask

  task automatic test_unsigned_latency();
    total++; if (rdy8 !== 1'b1) begin bad++; $display("FAIL lat_pre_rdy got=%0b exp=1", rdy8); end
    a8 = 8'd255; b8 = 8'd255; s8 = 1'b0; c8 = 1'b1; v8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0; a8 = 8'd1; b8 = 8'd2; c8 = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk); #1;
      total++; if (rdy8 !== 1'b0 || vo8 !== 1'b0) begin
        bad++; $display("FAIL lat_busy_e%0d got=rdy%0b/vo%0b exp=rdy0/vo0", e, rdy8, vo8);
      end
    end
    @(posedge clk); #1;
    total++; if (vo8 !== 1'b1 || rdy8 !== 1'b1) begin
      bad++; $display("FAIL lat_done got=vo%0b/rdy%0b exp=vo1/rdy1", vo8, rdy8);
    end
    total++; if (acc8 !== 20'h0FE01) begin bad++; $display("FAIL lat_acc got=%0h exp=fe01", acc8); end
    total++; if (of8 !== 1'b0) begin bad++; $display("FAIL lat_ovf got=%0b exp=0", of8); end
    @(posedge clk); #1;
    total++; if (vo8 !== 1'b0) begin bad++; $display("FAIL lat_pulse got=%0b exp=0", vo8); end
    total++; if (acc8 !== 20'h0FE01) begin bad++; $display("FAIL lat_stable got=%0h exp=fe01", acc8); end
  endtask

  task automatic test_signed_accumulate();
    op8(8'h80, 8'h80, 1'b1, 1'b1);
    total++; if (acc8 !== 20'd16384 || of8 !== 1'b0) begin
      bad++; $display("FAIL sgn_sq got=%0d/%0b exp=16384/0", acc8, of8);
    end
    op8(8'hFF, 8'h7F, 1'b1, 1'b0);
    total++; if (acc8 !== 20'h03F81 || of8 !== 1'b0) begin
      bad++; $display("FAIL sgn_acc got=%0d/%0b exp=16257/0", acc8, of8);
    end
  endtask

  task automatic test_overflow_wrap();
    op8(8'd255, 8'd255, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) op8(8'd255, 8'd255, 1'b0, 1'b0);
    total++; if (acc8 !== 20'd1040400 || of8 !== 1'b0) begin
      bad++; $display("FAIL ovf_16th got=%0d/%0b exp=1040400/0", acc8, of8);
    end
    op8(8'd255, 8'd255, 1'b0, 1'b0);
    total++; if (acc8 !== 20'd56849 || of8 !== 1'b1) begin
      bad++; $display("FAIL ovf_17th got=%0d/%0b exp=56849/1", acc8, of8);
    end
    op8(8'd0, 8'd0, 1'b0, 1'b0);
    total++; if (acc8 !== 20'd56849 || of8 !== 1'b1) begin
      bad++; $display("FAIL ovf_sticky got=%0d/%0b exp=56849/1", acc8, of8);
    end
    op8(8'd1, 8'd1, 1'b0, 1'b1);
    total++; if (acc8 !== 20'd1 || of8 !== 1'b0) begin
      bad++; $display("FAIL ovf_clear got=%0d/%0b exp=1/0", acc8, of8);
    end
  endtask

  task automatic test_reset_mid_op();
    int seen;
    op8(8'd7, 8'd9, 1'b0, 1'b1);
    total++; if (acc8 !== 20'd63) begin bad++; $display("FAIL rmid_pre got=%0d exp=63", acc8); end
    a8 = 8'd200; b8 = 8'd200; s8 = 1'b0; c8 = 1'b0; v8 = 1'b1;
    @(posedge clk); #1; v8 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; #2;
    total++; if (acc8 !== 20'd0 || of8 !== 1'b0 || rdy8 !== 1'b1 || vo8 !== 1'b0) begin
      bad++; $display("FAIL rmid_state got=%0d/%0b/%0b/%0b exp=0/0/1/0", acc8, of8, rdy8, vo8);
    end
    @(posedge clk); #1; rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; if (vo8) seen++; end
    total++; if (seen != 0) begin bad++; $display("FAIL rmid_novalid got=%0d exp=0", seen); end
    rst = 1'b1; #2; rst = 1'b0;
    op8(8'd3, 8'd5, 1'b0, 1'b1);
    total++; if (acc8 !== 20'd15 || of8 !== 1'b0) begin
      bad++; $display("FAIL rmid_next got=%0d/%0b exp=15/0", acc8, of8);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  va [4];
    logic [7:0]  vb [4];
    logic        vs [4];
    logic        vc [4];
    logic [19:0] ve [4];
    int nxt, got, last;
    va = '{8'd13, 8'd200, 8'hFB, 8'h80};
    vb = '{8'd11, 8'd3,   8'd7,  8'h80};
    vs = '{1'b0,  1'b0,   1'b1,  1'b0};
    vc = '{1'b1,  1'b0,   1'b0,  1'b1};
    ve = '{20'd143, 20'd743, 20'd708, 20'd16384};
    nxt = 0; got = 0; last = 0;
    v8 = 1'b1;
    for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
      if (rdy8 && nxt < 4) begin
        a8 = va[nxt]; b8 = vb[nxt]; s8 = vs[nxt]; c8 = vc[nxt]; nxt++;
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom);
        s8 = 1'($urandom_range(0, 1)); c8 = 1'($urandom_range(0, 1));
        if (rdy8) v8 = 1'b0;
      end
      @(posedge clk); #1;
      if (vo8) begin
        total++; if (acc8 !== ve[got] || of8 !== 1'b0) begin
          bad++; $display("FAIL b2b_res%0d got=%0d/%0b exp=%0d/0", got, acc8, of8, ve[got]);
        end
        total++; if (cyc - last != (got == 0 ? 6 : 7)) begin
          bad++; $display("FAIL b2b_gap%0d got=%0d exp=%0d", got, cyc - last, got == 0 ? 6 : 7);
        end
        last = cyc; got++;
      end
    end
    v8 = 1'b0;
    total++; if (got != 4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", got); end
  endtask

  task automatic test_random_model();
    logic [39:0]        macc, p, base;
    logic [40:0]        sum;
    logic               mov, evt, s, c;
    logic [15:0]        ta, tb;
    logic signed [31:0] ps;
    logic [31:0]        pu;
    int                 lat;
    macc = '0; mov = 1'b0;
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 4))
        0: ta = 16'hFFFF; 1: ta = 16'h8000; 2: ta = 16'h7FFF; default: ta = 16'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0: tb = 16'hFFFF; 1: tb = 16'h8000; 2: tb = 16'h7FFF; default: tb = 16'($urandom);
      endcase
      s = 1'($urandom_range(0, 1));
      c = (i == 0) || ($urandom_range(0, 99) == 0);
      ps = $signed(ta) * $signed(tb);
      pu = ta * tb;
      p = s ? {{8{ps[31]}}, ps} : {8'd0, pu};
      base = c ? 40'd0 : macc;
      sum = {1'b0, base} + {1'b0, p};
      evt = s ? ((base[39] == p[39]) && (sum[39] != base[39])) : sum[40];
      macc = sum[39:0];
      mov = (c ? 1'b0 : mov) | evt;

      a16 = ta; b16 = tb; s16 = s; c16 = c; v16 = 1'b1;
      lat = 0;
      while (!rdy16 && lat < 40) begin @(posedge clk); #1; lat++; end
      @(posedge clk); #1;
      v16 = 1'b0; a16 = ~ta; b16 = ~tb; s16 = ~s; c16 = ~c;
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (!vo16 && lat < 40);
      total++; if (lat != 10 || acc16 !== macc || of16 !== mov) begin
        bad++;
        $display("FAIL rand_op%0d got=%0h/%0b lat%0d exp=%0h/%0b lat10", i, acc16, of16, lat, macc, mov);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_unsigned_latency();
    test_signed_accumulate();
    test_overflow_wrap();
    test_reset_mid_op();
    test_back_to_back();
    test_random_model();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
